fir_cfg_ctrl: RTL and testbench
===============================

FIR_CFG_CTRL -- requirements
Module: fir_cfg_ctrl

Interface
REQ-001 Parameter pADDR_WIDTH, default 12: AXI-Lite and tap BRAM address width.
REQ-002 Parameter pDATA_WIDTH, default 32: data width.
REQ-003 Parameter Tape_Num, default 11: number of FIR taps.
REQ-004 Clocking: one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 awaddr/awvalid/awready  in/in/out  pADDR_WIDTH/1/1  AXI-Lite write address channel.
REQ-008 wdata/wvalid/wready  in/in/out  pDATA_WIDTH/1/1  AXI-Lite write data channel.
REQ-009 araddr/arvalid/arready  in/in/out  pADDR_WIDTH/1/1  AXI-Lite read address channel.
REQ-010 rdata/rvalid/rready  out/out/in  pDATA_WIDTH/1/1  AXI-Lite read data channel.
REQ-011 tap_WE/tap_EN/tap_Di/tap_A  out  4/1/pDATA_WIDTH/pADDR_WIDTH  tap BRAM port, driven to the BRAM.
REQ-012 tap_Do  in  pDATA_WIDTH  tap BRAM read data, 1-cycle latency.
REQ-013 eng_tap_A/eng_tap_EN  in  pADDR_WIDTH/1  FIR engine tap read request.
REQ-014 ap_start  out  1  start level to the engine.
REQ-015 reset_ap_start  in  1  engine acknowledge of start; level, sampled each cycle.
REQ-016 ap_done  in  1  engine completion pulse.
REQ-017 XferLength  out  pDATA_WIDTH  programmed stream length.

Function
REQ-018 Address map: 0x00 ap_ctrl {bit2 idle, bit1 done, bit0 start}; 0x10 data_length; 0x40+4*i tap i for i = 0..Tape_Num-1; all other addresses unmapped.
REQ-019 Status register fields: st_start, st_done, st_idle.
REQ-020 Engine status states: IDLE (st_idle=1), RUN (st_idle=0).
REQ-021 IDLE->RUN on a write of 0x00 with wdata[0]=1: st_start=1 and st_idle=0 on the next cycle.
REQ-022 A start write while in RUN SHALL be ignored.
REQ-023 st_start clears the cycle after reset_ap_start=1.
REQ-024 RUN->IDLE on an engine ap_done pulse: st_done=1 and st_idle=1 on the next cycle.
REQ-025 st_done SHALL clear in the cycle the rvalid/rready handshake completes for a read of 0x00 (read-to-clear).
REQ-026 If an engine ap_done pulse and that clearing handshake occur in the same cycle, done wins (st_done=1).
REQ-027 Write handshake: awready=wready=1 for exactly one cycle when awvalid&wvalid are both high and the block is not in a read-BRAM cycle; the write takes effect at that edge.
REQ-028 Writes to 0x10 update XferLength; writes to taps drive tap_EN=1, tap_WE=4'hF, tap_A=awaddr-0x40, tap_Di=wdata.
REQ-029 While st_idle=0, writes to 0x10 and to taps SHALL be accepted but discarded; no BRAM write occurs.
REQ-030 Writes to unmapped addresses SHALL be accepted and discarded.
REQ-031 Read FSM states: RIDLE (arready=1 when arvalid, and no write handshake this cycle), RWAIT (one cycle, BRAM data returning), RDATA (rvalid=1, rdata held stable until rready).
REQ-032 RDATA->RIDLE on rvalid&rready.
REQ-033 Read of a tap SHALL return tap_Do captured in RWAIT.
REQ-034 Read of a tap while st_idle=0 SHALL return 32'hFFFFFFFF.
REQ-035 Read of 0x00 returns {29'd0, st_idle, st_done, st_start}; read of 0x10 returns XferLength; unmapped reads return 0.
REQ-036 Tap BRAM arbitration: when st_idle=0 the engine owns the port (tap_A=eng_tap_A, tap_EN=eng_tap_EN, tap_WE=0).
REQ-037 When st_idle=1: an AXI write has priority over an AXI read; a read arriving in the same cycle is deferred one cycle.
REQ-038 At most one outstanding read; arready=0 outside RIDLE.

Reset
REQ-039 While rst is high, state resets to IDLE: st_idle=1, st_start=0, st_done=0, ap_start=0, XferLength=0.
REQ-040 While rst is high: awready=wready=arready=rvalid=0, rdata=0, read FSM=RIDLE, tap_WE=0, tap_EN=0.
REQ-041 rst asserted mid-transaction SHALL abandon the transaction; no BRAM write or rvalid follows deassertion.

Verification
REQ-042 Write taps 0..10 = {0,-10,-9,23,56,63,56,23,-9,-10,0} with st_idle=1, then read them back -> identical values; rvalid 2 cycles after the arvalid/arready handshake cycle.
REQ-043 Write 0x10=600, then 0x00=1 -> ap_start=1 and status read = 0x1; drive reset_ap_start=1 -> ap_start=0 next cycle, status read = 0x0.
REQ-044 While RUN, write tap 3 = 99 and read tap 3 -> rdata=0xFFFFFFFF; no tap_WE pulse; after done, tap 3 still reads 23.
REQ-045 Pulse ap_done -> status read = 0x6; second read = 0x4; a done pulse coincident with the clearing read handshake -> next read = 0x6.
REQ-046 Assert awvalid, wvalid and arvalid in the same cycle at st_idle=1 -> write accepted first, arready one cycle later; hold rready=0 for 5 cycles -> rdata stable throughout.
REQ-047 Assert rst during RDATA -> rvalid=0, st_idle=1, XferLength=0 the cycle after reset.

Source files
------------

// File: rtl/fir_cfg_ctrl.sv
// fir_cfg_ctrl: AXI-Lite configuration/status block for a FIR engine.
// It holds the ap_ctrl status (start/done/idle), the stream length, and
// arbitrates the tap-coefficient BRAM between AXI-Lite and the engine.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   awaddr/awvalid/awready           AXI-Lite write address channel
//   wdata/wvalid/wready              AXI-Lite write data channel
//   araddr/arvalid/arready           AXI-Lite read address channel
//   rdata/rvalid/rready              AXI-Lite read data channel
//   tap_WE/tap_EN/tap_Di/tap_A       tap BRAM port (to the BRAM)
//   tap_Do                           tap BRAM read data, 1-cycle latency
//   eng_tap_A/eng_tap_EN             engine tap read request
//   ap_start, reset_ap_start         start level to engine / engine ack
//   ap_done                          engine completion pulse
//   XferLength                       programmed stream length
//   read_state, run_state            debug view of the read and engine FSMs
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. awready/wready are raised together only when awvalid and wvalid
// are both high, so address and data are always taken in the same cycle.
// rvalid stays high with rdata stable until rready is seen.
module fir_cfg_ctrl #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int Tape_Num    = 11
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [pADDR_WIDTH-1:0] awaddr,
    input  logic                   awvalid,
    output logic                   awready,
    input  logic [pDATA_WIDTH-1:0] wdata,
    input  logic                   wvalid,
    output logic                   wready,
    input  logic [pADDR_WIDTH-1:0] araddr,
    input  logic                   arvalid,
    output logic                   arready,
    output logic [pDATA_WIDTH-1:0] rdata,
    output logic                   rvalid,
    input  logic                   rready,
    output logic [3:0]             tap_WE,
    output logic                   tap_EN,
    output logic [pDATA_WIDTH-1:0] tap_Di,
    output logic [pADDR_WIDTH-1:0] tap_A,
    input  logic [pDATA_WIDTH-1:0] tap_Do,
    input  logic [pADDR_WIDTH-1:0] eng_tap_A,
    input  logic                   eng_tap_EN,
    output logic                   ap_start,
    input  logic                   reset_ap_start,
    input  logic                   ap_done,
    output logic [pDATA_WIDTH-1:0] XferLength,
    output logic [1:0]             read_state,
    output logic                   run_state
);

    typedef enum logic [1:0] {RIDLE = 2'd0, RWAIT = 2'd1, RDATA = 2'd2} rd_state_t;
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} eng_state_t;

    localparam logic [pADDR_WIDTH-1:0] ADDR_CTRL = '0;
    localparam logic [pADDR_WIDTH-1:0] ADDR_LEN  = pADDR_WIDTH'(16);
    localparam logic [pADDR_WIDTH-1:0] TAP_BASE  = pADDR_WIDTH'(64);
    localparam logic [pADDR_WIDTH-1:0] TAP_END   = pADDR_WIDTH'(64 + 4 * Tape_Num);

    function automatic logic is_tap(input logic [pADDR_WIDTH-1:0] a);
        return (a >= TAP_BASE) && (a < TAP_END) && (a[1:0] == 2'b00);
    endfunction

    rd_state_t                rd_state, rd_next;
    eng_state_t               eng_state, eng_next;
    logic                     st_start, st_done, st_idle;
    logic                     wr_hs, rd_done, start_req;
    logic [pADDR_WIDTH-1:0]   rd_addr;
    logic                     rd_tap_ok;
    logic [pDATA_WIDTH-1:0]   rdata_q, rd_value;

    // Writes win over reads; the only time a write waits is the cycle the
    // BRAM is returning read data, so that cycle's tap_Do is never disturbed.
    assign wr_hs     = awvalid & wvalid & (rd_state != RWAIT) & ~rst;
    assign awready   = wr_hs;
    assign wready    = wr_hs;
    assign rd_done   = rvalid & rready;
    assign start_req = wr_hs & (awaddr == ADDR_CTRL) & wdata[0];

    // ---------------- engine status FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) eng_state <= IDLE;
        else     eng_state <= eng_next;
    end

    always_comb begin
        eng_next = eng_state;
        case (eng_state)
            IDLE:    if (start_req) eng_next = RUN;
            RUN:     if (ap_done)   eng_next = IDLE;
            default: eng_next = IDLE;
        endcase
    end

    always_comb begin
        st_idle   = (eng_state == IDLE);
        run_state = (eng_state == RUN);
    end

    // start/done flags; a done pulse outranks the read-to-clear of ap_ctrl
    always_ff @(posedge clk) begin
        if (rst) begin
            st_start <= 1'b0;
            st_done  <= 1'b0;
        end else begin
            if (st_idle && start_req) st_start <= 1'b1;
            else if (reset_ap_start)  st_start <= 1'b0;

            if (!st_idle && ap_done)                   st_done <= 1'b1;
            else if (rd_done && rd_addr == ADDR_CTRL)  st_done <= 1'b0;
        end
    end

    assign ap_start = st_start;

    // length register; ignored while the engine is running
    always_ff @(posedge clk) begin
        if (rst)                                          XferLength <= '0;
        else if (wr_hs && st_idle && awaddr == ADDR_LEN)  XferLength <= wdata;
    end

    // ---------------- read FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) rd_state <= RIDLE;
        else     rd_state <= rd_next;
    end

    always_comb begin
        rd_next = rd_state;
        case (rd_state)
            RIDLE:   if (arready) rd_next = RWAIT;
            RWAIT:   rd_next = RDATA;
            RDATA:   if (rd_done) rd_next = RIDLE;
            default: rd_next = RIDLE;
        endcase
    end

    always_comb begin
        arready    = 1'b0;
        rvalid     = 1'b0;
        read_state = rd_state;
        if (!rst) begin
            case (rd_state)
                RIDLE:   arready = arvalid & ~wr_hs;
                RDATA:   rvalid  = 1'b1;
                default: ;
            endcase
        end
    end

    // rd_tap_ok records whether the BRAM was actually read for this request;
    // a tap read while the engine owns the BRAM returns all ones instead.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_addr   <= '0;
            rd_tap_ok <= 1'b0;
        end else if (arready) begin
            rd_addr   <= araddr;
            rd_tap_ok <= st_idle & is_tap(araddr);
        end
    end

    always_comb begin
        rd_value = '0;
        if (rd_addr == ADDR_CTRL) begin
            rd_value[2:0] = {st_idle, st_done, st_start};
        end else if (rd_addr == ADDR_LEN) begin
            rd_value = XferLength;
        end else if (is_tap(rd_addr)) begin
            rd_value = rd_tap_ok ? tap_Do : '1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)                    rdata_q <= '0;
        else if (rd_state == RWAIT) rdata_q <= rd_value;
    end

    assign rdata = rst ? '0 : rdata_q;

    // ---------------- tap BRAM arbitration ----------------
    always_comb begin
        tap_EN = 1'b0;
        tap_WE = 4'h0;
        tap_A  = '0;
        tap_Di = '0;
        if (!rst) begin
            if (!st_idle) begin
                tap_EN = eng_tap_EN;
                tap_A  = eng_tap_A;
            end else if (wr_hs && is_tap(awaddr)) begin
                tap_EN = 1'b1;
                tap_WE = 4'hF;
                tap_A  = awaddr - TAP_BASE;
                tap_Di = wdata;
            end else if (arready && is_tap(araddr)) begin
                tap_EN = 1'b1;
                tap_A  = araddr - TAP_BASE;
            end
        end
    end

endmodule

// File: tb/tb_fir_cfg_ctrl.sv
module tb_fir_cfg_ctrl;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int NT = 11;

    logic          clk;
    logic          rst;
    logic [AW-1:0] awaddr;
    logic          awvalid;
    logic          awready;
    logic [DW-1:0] wdata;
    logic          wvalid;
    logic          wready;
    logic [AW-1:0] araddr;
    logic          arvalid;
    logic          arready;
    logic [DW-1:0] rdata;
    logic          rvalid;
    logic          rready;
    logic [3:0]    tap_WE;
    logic          tap_EN;
    logic [DW-1:0] tap_Di;
    logic [AW-1:0] tap_A;
    logic [DW-1:0] tap_Do;
    logic [AW-1:0] eng_tap_A;
    logic          eng_tap_EN;
    logic          ap_start;
    logic          reset_ap_start;
    logic          ap_done;
    logic [DW-1:0] XferLength;
    logic [1:0]    read_state;
    logic          run_state;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;
    int we_in_run = 0;

    fir_cfg_ctrl #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW), .Tape_Num(NT)) dut (
        .clk(clk), .rst(rst),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wvalid(wvalid), .wready(wready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rvalid(rvalid), .rready(rready),
        .tap_WE(tap_WE), .tap_EN(tap_EN), .tap_Di(tap_Di), .tap_A(tap_A),
        .tap_Do(tap_Do),
        .eng_tap_A(eng_tap_A), .eng_tap_EN(eng_tap_EN),
        .ap_start(ap_start), .reset_ap_start(reset_ap_start), .ap_done(ap_done),
        .XferLength(XferLength),
        .read_state(read_state), .run_state(run_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- tap BRAM (1-cycle read latency) ----------------
    logic [DW-1:0] mem [0:255];
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        tap_Do = '0;
    end
    always @(posedge clk) begin
        if (tap_EN) begin
            if (tap_WE != 4'h0) mem[tap_A[9:2]] <= tap_Di;
            tap_Do <= mem[tap_A[9:2]];
        end
    end

    // engine tap read traffic, only meaningful while running
    always @(posedge clk) begin
        #1;
        eng_tap_EN = 1'($urandom_range(0, 1));
        eng_tap_A  = AW'(4 * $urandom_range(0, NT - 1));
    end

    // ---------------- behavioural model ----------------
    bit            m_idle = 1;
    bit            m_start = 0;
    bit            m_done = 0;
    logic [DW-1:0] m_len = '0;
    logic [DW-1:0] m_taps [NT];
    int            m_ar_age = 0;   // 0 none outstanding, 1 BRAM returning, 2 response offered
    logic [AW-1:0] m_rd_addr = '0;
    bit            m_rd_ok = 0;
    logic [DW-1:0] m_rd_exp = '0;

    function automatic bit tap_addr(input logic [AW-1:0] a);
        return (int'(a) >= 64) && (int'(a) < 64 + 4 * NT) && (a[1:0] == 2'b00);
    endfunction

    function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a, input bit ok);
        if (a == 12'h000) return {29'd0, m_idle, m_done, m_start};
        if (a == 12'h010) return m_len;
        if (tap_addr(a)) return ok ? m_taps[(int'(a) - 64) / 4] : 32'hFFFF_FFFF;
        return 32'h0;
    endfunction

    bit            e_wr, e_ar, e_rvalid, e_en;
    logic [3:0]    e_we;
    logic [AW-1:0] e_a;
    logic [DW-1:0] e_di;

    always_comb begin
        e_wr     = !rst && awvalid && wvalid && (m_ar_age != 1);
        e_ar     = !rst && (m_ar_age == 0) && arvalid && !e_wr;
        e_rvalid = !rst && (m_ar_age == 2);
        e_en     = 1'b0;
        e_we     = 4'h0;
        e_a      = '0;
        e_di     = '0;
        if (!rst) begin
            if (!m_idle) begin
                e_en = eng_tap_EN;
                e_a  = eng_tap_A;
            end else if (e_wr && tap_addr(awaddr)) begin
                e_en = 1'b1;
                e_we = 4'hF;
                e_a  = awaddr - 12'h040;
                e_di = wdata;
            end else if (e_ar && tap_addr(araddr)) begin
                e_en = 1'b1;
                e_a  = araddr - 12'h040;
            end
        end
    end

    always @(posedge clk) begin : model_update
        bit wr, ar, startw, clear_done;
        wr = e_wr;
        ar = e_ar;
        clear_done = 0;
        if (rst) begin
            m_idle = 1; m_start = 0; m_done = 0; m_len = '0; m_ar_age = 0;
        end else begin
            startw = wr && (awaddr == 12'h000) && wdata[0] && m_idle;
            if (m_ar_age == 2 && rready) begin
                m_ar_age = 0;
                clear_done = (m_rd_addr == 12'h000);
            end else if (m_ar_age == 1) begin
                m_ar_age = 2;
                m_rd_exp = model_read(m_rd_addr, m_rd_ok);
            end
            if (ar) begin
                m_ar_age  = 1;
                m_rd_addr = araddr;
                m_rd_ok   = m_idle && tap_addr(araddr);
            end
            if (wr && m_idle) begin
                if (awaddr == 12'h010) m_len = wdata;
                if (tap_addr(awaddr)) m_taps[(int'(awaddr) - 64) / 4] = wdata;
            end
            if (startw) m_start = 1;
            else if (reset_ap_start) m_start = 0;
            if (!m_idle && ap_done) m_done = 1;
            else if (clear_done) m_done = 0;
            if (startw) m_idle = 0;
            else if (!m_idle && ap_done) m_idle = 1;
        end
    end

    // ---------------- scoreboard compare, every cycle ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            check("awready", awready, e_wr);
            check("wready", wready, e_wr);
            check("arready", arready, e_ar);
            check("rvalid", rvalid, e_rvalid);
            if (e_rvalid) check("rdata", rdata, m_rd_exp);
            if (rst) check("rdata_in_reset", rdata, 32'h0);
            check("ap_start", ap_start, m_start);
            check("XferLength", XferLength, m_len);
            check("tap_EN", tap_EN, e_en);
            check("tap_WE", tap_WE, e_we);
            if (e_en) check("tap_A", tap_A, e_a);
            if (e_we != 4'h0) check("tap_Di", tap_Di, e_di);
            if (!m_idle && tap_WE != 4'h0) we_in_run++;
        end
    end

    // ---------------- driver tasks (enter and leave at posedge+1) ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit got;
        got = 0;
        awaddr = a; wdata = d; awvalid = 1; wvalid = 1;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            got = awready;
            @(posedge clk); #1;
        end
        awvalid = 0; wvalid = 0;
        if (!got) check("write_timeout", 32'd0, 32'd1);
    endtask

    task automatic ar_phase(input logic [AW-1:0] a);
        bit got;
        got = 0;
        araddr = a; arvalid = 1;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            got = arready;
            @(posedge clk); #1;
        end
        arvalid = 0;
        if (!got) check("ar_timeout", 32'd0, 32'd1);
    endtask

    // waits for rvalid; counts cycles from the address handshake
    task automatic r_phase(output logic [DW-1:0] d, output int lat);
        bit got;
        got = 0; lat = 0; d = '0;
        for (int n = 1; n <= 20 && !got; n++) begin
            @(negedge clk);
            if (rvalid) begin
                got = 1; lat = n; d = rdata;
            end
            @(posedge clk); #1;
        end
        if (!got) check("rvalid_timeout", 32'd0, 32'd1);
    endtask

    task automatic rd_check(input string name, input logic [AW-1:0] a, input logic [DW-1:0] exp);
        logic [DW-1:0] d;
        int lat;
        rready = 1;
        ar_phase(a);
        r_phase(d, lat);
        check(name, d, exp);
        check({name, "_latency"}, 32'(lat), 32'd2);
    endtask

    // ---------------- directed test sequence ----------------
    int coef [NT] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};

    initial begin
        logic [DW-1:0] d;
        int lat;
        rst = 1; awaddr = '0; awvalid = 0; wdata = '0; wvalid = 0;
        araddr = '0; arvalid = 0; rready = 1; reset_ap_start = 0; ap_done = 0;
        eng_tap_A = '0; eng_tap_EN = 0;
        @(posedge clk);
        chk_en = 1;
        #1;
        tick(2);
        rst = 0;
        check("len_after_reset", XferLength, 32'd0);
        check("ap_start_after_reset", ap_start, 1'b0);
        rd_check("status_reset", 12'h000, 32'h4);

        // tap coefficients written and read back while idle
        for (int i = 0; i < NT; i++) axi_write(AW'(64 + 4 * i), 32'(coef[i]));
        for (int i = 0; i < NT; i++) rd_check("tap_readback", AW'(64 + 4 * i), 32'(coef[i]));
        rd_check("tap3_literal", 12'h04C, 32'd23);
        rd_check("tap1_literal", 12'h044, 32'hFFFF_FFF6);
        rd_check("unmapped_read", 12'h020, 32'h0);
        axi_write(12'h030, 32'h1234);
        rd_check("unmapped_after_write", 12'h030, 32'h0);

        // length and start
        axi_write(12'h010, 32'd600);
        rd_check("len_read", 12'h010, 32'd600);
        axi_write(12'h000, 32'h1);
        check("ap_start_set", ap_start, 1'b1);
        rd_check("status_run", 12'h000, 32'h1);
        reset_ap_start = 1;
        tick(1);
        reset_ap_start = 0;
        check("ap_start_cleared", ap_start, 1'b0);
        rd_check("status_acked", 12'h000, 32'h0);
        axi_write(12'h000, 32'h1);
        rd_check("start_ignored_in_run", 12'h000, 32'h0);

        // config writes discarded while running
        axi_write(12'h010, 32'd5);
        axi_write(12'h04C, 32'd99);
        rd_check("tap3_while_run", 12'h04C, 32'hFFFF_FFFF);
        rd_check("len_while_run", 12'h010, 32'd600);
        check("no_tap_we_in_run", 32'(we_in_run), 32'd0);

        // done and read-to-clear
        ap_done = 1;
        tick(1);
        ap_done = 0;
        rd_check("status_done", 12'h000, 32'h6);
        rd_check("status_done_cleared", 12'h000, 32'h4);
        rd_check("tap3_after_run", 12'h04C, 32'd23);

        // done pulse coincident with the clearing handshake
        axi_write(12'h000, 32'h1);
        reset_ap_start = 1;
        tick(1);
        reset_ap_start = 0;
        rready = 0;
        ar_phase(12'h000);
        r_phase(d, lat);
        check("status_before_done", d, 32'h0);
        rready = 1; ap_done = 1;
        tick(1);
        ap_done = 0;
        rd_check("status_done_wins", 12'h000, 32'h6);
        rd_check("status_after_win", 12'h000, 32'h4);

        // simultaneous write and read: write first, read deferred a cycle
        awaddr = 12'h010; wdata = 32'd7; awvalid = 1; wvalid = 1;
        araddr = 12'h010; arvalid = 1; rready = 0;
        @(negedge clk);
        check("simul_awready", awready, 1'b1);
        check("simul_arready_deferred", arready, 1'b0);
        @(posedge clk); #1;
        awvalid = 0; wvalid = 0;
        @(negedge clk);
        check("simul_arready", arready, 1'b1);
        @(posedge clk); #1;
        arvalid = 0;
        r_phase(d, lat);
        check("simul_rdata", d, 32'd7);
        check("simul_latency", 32'(lat), 32'd2);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rdata_held", rdata, 32'd7);
            check("rvalid_held", rvalid, 1'b1);
            @(posedge clk); #1;
        end
        rready = 1;
        tick(1);

        // reset in the middle of a read response
        rready = 0;
        ar_phase(12'h010);
        r_phase(d, lat);
        check("pre_reset_rdata", d, 32'd7);
        rst = 1;
        tick(1);
        rst = 0;
        check("rvalid_after_reset", rvalid, 1'b0);
        check("len_after_mid_reset", XferLength, 32'd0);
        rready = 1;
        tick(3);
        rd_check("status_after_mid_reset", 12'h000, 32'h4);
        rd_check("len_read_after_reset", 12'h010, 32'd0);

        tick(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
